jogo_memoria_param: RTL
=======================

# jogo_memoria_param

Parametrised memory-game core (Genius/Simon), successor to the fixed 8-button game top. It generates a pseudo-random sequence internally and shows it on `leds`. It then checks the player's button presses against the sequence, under a difficulty-selected timeout. Button count, sequence depth, timing and game mode are configurable. The block sits between the board buttons/LEDs and the display decoders, which consume `score`, `tempo_de_jogo` and `db_estado`.

## Interface
- `N_BOTOES`, default 8: number of buttons and LEDs. Must be a power of two, 2..16. `IW = log2(N_BOTOES)`.
- `PROFUNDIDADE`, default 16: sequence length, 2..64. `SW = clog2(PROFUNDIDADE+1)`.
- `MOSTRA_CICLOS`, default 1000: cycles each element is lit, and also the dark gap after it.
- `TIMEOUT_FACIL`, default 5000: press-wait limit in cycles when `dificuldade=0`.
- `TIMEOUT_DIFICIL`, default 2000: press-wait limit in cycles when `dificuldade=1`.
- `CICLOS_POR_UNIDADE`, default 1000: prescale for the `tempo_de_jogo` count.
- `clock`, in, 1: the single clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `jogar`, in, 1: start/restart request, level-sampled.
- `botoes`, in, `N_BOTOES`: button levels, 1 = pressed. Already synchronised.
- `dificuldade`, in, 1: 0 = easy, 1 = hard. Sampled at start.
- `modo`, in, 1: 0 = fixed (one round of the full sequence), 1 = growing (Simon). Sampled at start.
- `leds`, out, `N_BOTOES`: one-hot display of the sequence.
- `pronto`, out, 1: game finished, any outcome.
- `acertou`, out, 1: game won.
- `errou`, out, 1: wrong press.
- `timeout`, out, 1: press not made in time.
- `score`, out, `SW`: correct presses (fixed mode) or completed rounds (growing mode).
- `tempo_de_jogo`, out, 16: elapsed play time in `CICLOS_POR_UNIDADE` units.
- `db_estado`, out, 4: state code.

## Operation
- **Reset** forces state INICIAL (0). All outputs reset to 0: `leds`, `pronto`, `acertou`, `errou`, `timeout`, `score`, `tempo_de_jogo`, `db_estado`. Reset is taken in any state, including mid-game, and overrides `jogar` in the same cycle.
- **LFSR.** A 16-bit LFSR, polynomial x^16+x^14+x^13+x^11+1, runs every cycle from seed 16'hACE1 after reset.
- **INICIAL (0).** On `jogar=1`: latch `dificuldade` and `modo`; clear `score`, `tempo_de_jogo`, the element index `i`, and `limite`. Go to GERA.
  - `limite` starts at 0 in growing mode and at `PROFUNDIDADE-1` in fixed mode.
- **GERA (1).** Writes `mem[k] = lfsr[IW-1:0]` for k = 0..PROFUNDIDADE-1, one per cycle. This takes exactly `PROFUNDIDADE` cycles, then the state goes to MOSTRA with `i=0`.
- **MOSTRA (2).** For each element `i = 0..limite`:
  - `leds = 1 << mem[i]` for `MOSTRA_CICLOS` cycles, then `leds = 0` for `MOSTRA_CICLOS` cycles.
  - After element `limite`, go to ESPERA with `i=0`.
  - Presses during MOSTRA are ignored and do not count as edges later.
- **ESPERA (3).**
  - A press event is `botoes != 0` this cycle with `botoes == 0` the previous cycle. The edge register is forced to "previous = current" on entry, so a button already held on entry does not trigger.
  - On a press event, capture `botoes` and go to COMPARA.
  - The wait counter counts cycles spent in ESPERA. When it reaches the latched timeout limit without a press, go to FIM_TIMEOUT.
  - A press on the same cycle as expiry wins over the timeout.
- **COMPARA (4)**, one cycle. Correct means the capture is exactly one-hot and equals `1 << mem[i]`; a multi-button capture is always wrong.
  - Wrong: go to FIM_ERRO.
  - Correct, fixed mode: `score++`.
  - Correct with `i < limite`: `i++`, go to ESPERA with the timeout counter reset.
  - Correct with `i == limite`: go to PROXIMA_RODADA.
- **PROXIMA_RODADA (5)**, one cycle.
  - Growing mode: `score++`.
  - If `limite == PROFUNDIDADE-1`: go to FIM_ACERTO.
  - Otherwise: `limite++`, `i=0`, go to MOSTRA.
- **Final states:** FIM_ACERTO (6), FIM_ERRO (7), FIM_TIMEOUT (8).
  - `pronto=1` plus the matching flag. The outputs are held, and `leds=0`.
  - `jogar=1` restarts exactly as from INICIAL. The LFSR keeps running, so the new sequence differs.
- **`tempo_de_jogo`** advances by one every `CICLOS_POR_UNIDADE` cycles while in states 2–5. It saturates at 16'hFFFF, freezes in the final states, and is cleared at start.
- **Score** is at most `PROFUNDIDADE` and never wraps.
- `jogar` is ignored in states 1–5.

## Timing
- Start latency: `jogar` high in cycle t puts the block in GERA at t+1 and MOSTRA at t+1+PROFUNDIDADE. The first LED lights in that same cycle.
- A press event at cycle t puts the block in COMPARA at t+1; the outcome state is entered at t+2.
- Timeout: entering ESPERA at cycle e with no press puts the block in FIM_TIMEOUT at e+limit.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Flags change in the same cycle the state register enters the final state.

## Test plan
Bench parameters: `N_BOTOES=4`, `PROFUNDIDADE=4`, `MOSTRA_CICLOS=2`, `TIMEOUT_FACIL=10`, `TIMEOUT_DIFICIL=5`, `CICLOS_POR_UNIDADE=3`. Expected values are taken from a reference model of the LFSR, or read back from `leds`.

1. **Fixed-mode win.** `modo=0`, play all 4 correct presses. Expect `pronto=1`, `acertou=1`, `score=4`, `db_estado=6`.
2. **Growing-mode win.** `modo=1`: 4 rounds of 1, 2, 3, 4 shown elements, each echoed correctly. Expect `score=4`, `acertou=1`. Check `leds` pulse counts per round are 1, 2, 3, 4.
3. **Wrong and multi-button presses.** A wrong button in round 2 of growing mode gives `errou=1`, `score=1`, `db_estado=7`. Separately, a two-button press gives `errou=1`.
4. **Timeout.** With `dificuldade=1` and no press, `timeout=1` exactly 5 cycles after entering ESPERA. With `dificuldade=0`, a press at cycle 10 (expiry cycle) is accepted.
5. **Ignored and held inputs.** A button held through MOSTRA into ESPERA gives no press event. `jogar` pulses during GERA/MOSTRA have no effect.
6. **Reset and restart.** Reset in ESPERA gives INICIAL next cycle with all outputs 0. `jogar` from FIM_ERRO restarts with `score=0` and `tempo_de_jogo=0`.

Source files
------------

// File: rtl/jogo_memoria_param.sv
// rtl/jogo_memoria_param.sv - parametrised Genius/Simon memory-game core
module jogo_memoria_param #(
    parameter int N_BOTOES           = 8,
    parameter int PROFUNDIDADE       = 16,
    parameter int MOSTRA_CICLOS      = 1000,
    parameter int TIMEOUT_FACIL      = 5000,
    parameter int TIMEOUT_DIFICIL    = 2000,
    parameter int CICLOS_POR_UNIDADE = 1000,
    localparam int IW = $clog2(N_BOTOES),
    localparam int SW = $clog2(PROFUNDIDADE + 1),
    localparam int XW = $clog2(PROFUNDIDADE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                dificuldade,
    input  logic                modo,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [SW-1:0]       score,
    output logic [15:0]         tempo_de_jogo,
    output logic [3:0]          db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        GERA           = 4'd1,
        MOSTRA         = 4'd2,
        ESPERA         = 4'd3,
        COMPARA        = 4'd4,
        PROXIMA_RODADA = 4'd5,
        FIM_ACERTO     = 4'd6,
        FIM_ERRO       = 4'd7,
        FIM_TIMEOUT    = 4'd8
    } estado_t;

    estado_t estado, proximo;

    logic [15:0]         lfsr;
    logic [IW-1:0]       mem [PROFUNDIDADE];
    logic [XW-1:0]       k, i, limite;
    logic                dif_l, modo_l;
    logic [31:0]         cnt_mostra, cnt_espera, cnt_pre, lim_espera;
    logic                apagado;
    logic [N_BOTOES-1:0] anterior, captura, alvo;
    logic                inicio, evento, expirou, fim_fase, correto, ultimo, ultima_rodada;

    always_comb begin
        alvo = '0;
        alvo[mem[i]] = 1'b1;
    end

    always_comb begin
        inicio        = jogar && (estado == INICIAL || estado == FIM_ACERTO ||
                                  estado == FIM_ERRO || estado == FIM_TIMEOUT);
        // anterior tracks botoes every cycle, so a press begun before ESPERA never looks like an edge
        evento        = (botoes != '0) && (anterior == '0);
        lim_espera    = dif_l ? 32'(TIMEOUT_DIFICIL) : 32'(TIMEOUT_FACIL);
        expirou       = (cnt_espera == lim_espera - 32'd1);
        fim_fase      = (cnt_mostra == 32'(MOSTRA_CICLOS - 1));
        correto       = (captura == alvo);
        ultimo        = (i == limite);
        ultima_rodada = (limite == XW'(PROFUNDIDADE - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                if (jogar) proximo = GERA;
            GERA:
                if (k == XW'(PROFUNDIDADE - 1)) proximo = MOSTRA;
            MOSTRA:
                if (fim_fase && apagado && ultimo) proximo = ESPERA;
            ESPERA:
                if (evento)       proximo = COMPARA;
                else if (expirou) proximo = FIM_TIMEOUT;
            COMPARA:
                if (!correto)    proximo = FIM_ERRO;
                else if (ultimo) proximo = PROXIMA_RODADA;
                else             proximo = ESPERA;
            PROXIMA_RODADA:
                proximo = ultima_rodada ? FIM_ACERTO : MOSTRA;
            default:
                proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (estado == GERA) mem[k] <= lfsr[IW-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr          <= 16'hACE1;
            k             <= '0;
            i             <= '0;
            limite        <= '0;
            dif_l         <= 1'b0;
            modo_l        <= 1'b0;
            cnt_mostra    <= '0;
            cnt_espera    <= '0;
            cnt_pre       <= '0;
            apagado       <= 1'b0;
            anterior      <= '0;
            captura       <= '0;
            score         <= '0;
            tempo_de_jogo <= '0;
        end else begin
            lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            anterior   <= botoes;
            cnt_espera <= (estado == ESPERA) ? cnt_espera + 32'd1 : 32'd0;

            if (estado inside {MOSTRA, ESPERA, COMPARA, PROXIMA_RODADA}) begin
                if (cnt_pre == 32'(CICLOS_POR_UNIDADE - 1)) begin
                    cnt_pre <= '0;
                    if (tempo_de_jogo != 16'hFFFF) tempo_de_jogo <= tempo_de_jogo + 16'd1;
                end else begin
                    cnt_pre <= cnt_pre + 32'd1;
                end
            end

            if (estado != MOSTRA) begin
                cnt_mostra <= '0;
                apagado    <= 1'b0;
            end

            case (estado)
                GERA: begin
                    k <= k + 1'b1;
                    i <= '0;
                end
                MOSTRA:
                    if (fim_fase) begin
                        cnt_mostra <= '0;
                        apagado    <= ~apagado;
                        if (apagado) i <= ultimo ? '0 : i + 1'b1;
                    end else begin
                        cnt_mostra <= cnt_mostra + 32'd1;
                    end
                ESPERA:
                    if (evento) captura <= botoes;
                COMPARA:
                    if (correto) begin
                        if (!modo_l && score != SW'(PROFUNDIDADE)) score <= score + 1'b1;
                        if (!ultimo) i <= i + 1'b1;
                    end
                PROXIMA_RODADA: begin
                    if (modo_l && score != SW'(PROFUNDIDADE)) score <= score + 1'b1;
                    if (!ultima_rodada) limite <= limite + 1'b1;
                    i <= '0;
                end
                default: ;
            endcase

            if (inicio) begin
                dif_l         <= dificuldade;
                modo_l        <= modo;
                score         <= '0;
                tempo_de_jogo <= '0;
                cnt_pre       <= '0;
                i             <= '0;
                k             <= '0;
                limite        <= modo ? '0 : XW'(PROFUNDIDADE - 1);
            end
        end
    end

    always_comb begin
        leds      = (estado == MOSTRA && !apagado) ? alvo : '0;
        acertou   = (estado == FIM_ACERTO);
        errou     = (estado == FIM_ERRO);
        timeout   = (estado == FIM_TIMEOUT);
        pronto    = acertou || errou || timeout;
        db_estado = estado;
    end

endmodule
